gp_reg_bank: RTL
================

# gp_reg_bank

Parametrised general-purpose register bank for the Mini SRC datapath, successor to the 16×32 bus-facing register abstraction. It accepts one-hot write and two independent one-hot read select vectors (ready for the 3-bus datapath), encodes them internally, and adds four capabilities:
- one-hot violation detection;
- optional write-to-read bypass;
- R0-as-zero base addressing (BAout);
- a background sweep clear that walks the bank one register per cycle while reporting busy.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 16, number of registers; power of two, 2..64
- CLR_VAL, 0 (DATA_W bits), value loaded by reset and by sweep clear
- BYPASS, 1, 1 = a read of the register being written this cycle returns the write data
- clk  input  1  rising-edge clock
- reg_clear  input  1  synchronous, active-high reset
- BusMuxOut  input  DATA_W  write data from the bus
- GRin  input  NREGS  one-hot write-enable vector
- GRoutA  input  NREGS  one-hot read select, port A
- GRoutB  input  NREGS  one-hot read select, port B
- BAout  input  1  base-address read; applies to port A only
- sweep_req  input  1  single-cycle pulse that starts a background clear
- BusMuxIn  output  DATA_W  port A read data
- BusMuxIn2  output  DATA_W  port B read data
- sweep_busy  output  1  high while a sweep clear is in progress
- onehot_err  output  1  sticky flag: some select vector had more than one bit set
- written  output  NREGS  bit i set once register i has been written since its last clear

## Operation
- Each select vector is classified every cycle:
  - zero bits set = idle;
  - exactly one bit set = valid, encoded to a log2(NREGS)-bit address;
  - two or more bits set = violation.
- Write: on a rising edge with GRin valid and no sweep in progress, reg[addr] <= BusMuxOut and written[addr] <= 1.
- GRin violation: no register changes; onehot_err <= 1.
- Port reads are combinational from the array. Port A and port B are identical except for BAout.
  - Valid select: the port outputs reg[addr].
  - Idle or violating select: the port outputs 0. A violation also sets onehot_err on the next edge.
- BAout: when BAout = 1 and GRoutA selects R0, BusMuxIn = 0 regardless of reg[0]. For any other register, BAout has no effect.
- Bypass (BYPASS = 1): if GRin is valid, the write is permitted, and a port's address equals the write address, that port outputs BusMuxOut combinationally.
  - The BAout-R0 zero rule takes priority over bypass.
  - BYPASS = 0: the port shows the old value until the edge.
- Sweep FSM, states IDLE and SWEEP, with a pointer ptr of log2(NREGS) bits:
  - IDLE -> SWEEP on sweep_req = 1; ptr <= 0.
  - In SWEEP, each edge: reg[ptr] <= CLR_VAL, written[ptr] <= 0, ptr <= ptr + 1.
  - SWEEP -> IDLE on the edge that clears reg[NREGS-1]; ptr wraps to 0.
  - sweep_busy = (state == SWEEP).
  - sweep_req is ignored while in SWEEP.
  - GRin writes are dropped while in SWEEP. The caller must stall; no error is raised.
  - Reads stay live during SWEEP and show the partially cleared bank.
- reg_clear (dominates everything) at the edge:
  - all registers <= CLR_VAL;
  - written <= 0;
  - onehot_err <= 0;
  - state <= IDLE, ptr <= 0.
- Outputs after reset:
  - sweep_busy = 0, onehot_err = 0, written = 0;
  - BusMuxIn and BusMuxIn2 = CLR_VAL if a valid select is applied, 0 if idle.

## Timing
- Write latency: 1 edge. With BYPASS = 0, data is visible on a read port in the cycle after the write.
- Read latency: 0 cycles (combinational from select vectors and the array).
- Sweep duration: exactly NREGS cycles, from the edge after sweep_req to the edge at which sweep_busy falls.
- sweep_req and GRin in the same cycle while IDLE: the write happens (state is still IDLE at that edge), then the sweep starts. The sweep later clears that register.
- reg_clear mid-sweep: the sweep aborts and the bank is fully cleared at that edge; sweep_busy = 0 next cycle.
- onehot_err sets on the edge following the violating cycle and holds until reg_clear.

## Test plan
- Reset then write: assert reg_clear for 1 cycle; GRin = 0x0008 with BusMuxOut = 0xDEADBEEF; next cycle GRoutA = 0x0008 -> BusMuxIn = 0xDEADBEEF, written = 0x0008, onehot_err = 0.
- Bypass: BYPASS = 1; GRin = GRoutB = 0x0020 with BusMuxOut = 0x12345678 -> BusMuxIn2 = 0x12345678 in the same cycle. Repeat with BYPASS = 0 -> old value in the same cycle, new value next cycle.
- BAout: write 0x55 to R0; GRoutA = 0x0001 with BAout = 1 -> BusMuxIn = 0; BAout = 0 -> 0x55; GRoutB = 0x0001 with BAout = 1 -> BusMuxIn2 = 0x55.
- One-hot violation: write 0xAA to R1 and 0xBB to R2; GRin = 0x0006 with BusMuxOut = 0xFF -> R1 = 0xAA and R2 = 0xBB unchanged, onehot_err = 1 and stays 1 until reg_clear. GRoutA = 0x0003 -> BusMuxIn = 0.
- Sweep: fill all 16 registers with nonzero values; pulse sweep_req -> sweep_busy high for exactly 16 cycles. During the sweep, GRin = 0x8000 with BusMuxOut = 0x1 is dropped. After the sweep: every register = 0, written = 0.
- Reset mid-sweep: pulse sweep_req, assert reg_clear after 5 sweep cycles -> all registers = CLR_VAL and sweep_busy = 0 on the next cycle; a new sweep_req restarts from ptr 0.

Source files
------------

// File: rtl/gp_reg_bank.sv
// General-purpose register bank with one-hot write and dual one-hot read selects,
// optional write-to-read bypass, R0-as-zero base addressing and a background sweep clear.
module gp_reg_bank #(
    parameter int unsigned          DATA_W  = 32,
    parameter int unsigned          NREGS   = 16,
    parameter logic [DATA_W-1:0]    CLR_VAL = '0,
    parameter bit                   BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              reg_clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic [NREGS-1:0]  GRin,
    input  logic [NREGS-1:0]  GRoutA,
    input  logic [NREGS-1:0]  GRoutB,
    input  logic              BAout,
    input  logic              sweep_req,
    output logic [DATA_W-1:0] BusMuxIn,
    output logic [DATA_W-1:0] BusMuxIn2,
    output logic              sweep_busy,
    output logic              onehot_err,
    output logic [NREGS-1:0]  written
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e            state, stateNext;
    logic [AW-1:0]     ptr, ptrNext;
    logic [DATA_W-1:0] regs [NREGS];

    // Returns {violation, valid, address}; address is meaningful only when valid.
    function automatic logic [AW+1:0] encode(input logic [NREGS-1:0] sel);
        logic [AW-1:0] addr;
        int unsigned   cnt;
        addr = '0;
        cnt  = 0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel[i]) begin
                addr = AW'(i);
                cnt  = cnt + 1;
            end
        end
        return {cnt > 1, cnt == 1, addr};
    endfunction

    logic [AW+1:0] encW, encA, encB;
    logic          wrValid, aValid, bValid, anyViol, wrPermit;
    logic [AW-1:0] wrAddr, aAddr, bAddr;

    always_comb begin
        encW     = encode(GRin);
        encA     = encode(GRoutA);
        encB     = encode(GRoutB);
        wrValid  = encW[AW];
        aValid   = encA[AW];
        bValid   = encB[AW];
        wrAddr   = encW[AW-1:0];
        aAddr    = encA[AW-1:0];
        bAddr    = encB[AW-1:0];
        anyViol  = encW[AW+1] | encA[AW+1] | encB[AW+1];
        wrPermit = wrValid && (state == StIdle);
    end

    // Base-address zero rule wins over bypass on port A.
    always_comb begin
        BusMuxIn = '0;
        if (aValid && !(BAout && aAddr == '0)) begin
            if (BYPASS && wrPermit && aAddr == wrAddr) BusMuxIn = BusMuxOut;
            else                                      BusMuxIn = regs[aAddr];
        end
    end

    always_comb begin
        BusMuxIn2 = '0;
        if (bValid) begin
            if (BYPASS && wrPermit && bAddr == wrAddr) BusMuxIn2 = BusMuxOut;
            else                                      BusMuxIn2 = regs[bAddr];
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        unique case (state)
            StIdle: begin
                if (sweep_req) begin
                    stateNext = StSweep;
                    ptrNext   = '0;
                end
            end
            StSweep: begin
                ptrNext = ptr + 1'b1;
                if (ptr == AW'(NREGS - 1)) stateNext = StIdle;
            end
            default: stateNext = StIdle;
        endcase
    end

    assign sweep_busy = (state == StSweep);

    always_ff @(posedge clk) begin
        if (reg_clear) begin
            state      <= StIdle;
            ptr        <= '0;
            onehot_err <= 1'b0;
            written    <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= CLR_VAL;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            if (anyViol) onehot_err <= 1'b1;
            if (state == StSweep) begin
                regs[ptr]    <= CLR_VAL;
                written[ptr] <= 1'b0;
            end else if (wrValid) begin
                regs[wrAddr]    <= BusMuxOut;
                written[wrAddr] <= 1'b1;
            end
        end
    end

endmodule
